// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS func codes and FSM states.
package mdu_pkg;

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: y = neg ? -a : a.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mdu_seq_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFHI/MFLO/MTHI/MTLO access.
module mdu_seq_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   orig_a_q, orig_a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_op_q, div_op_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic               is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
    assign sign_a    = is_signed & rs_val[WIDTH-1];
    assign sign_b    = is_signed & rt_val[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.neg(sign_a), .a(rs_val), .y(mag_a));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.neg(sign_b), .a(rt_val), .y(mag_b));
    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_res_q), .a(acc_q), .y(prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_res_q), .a(acc_q[WIDTH-1:0]), .y(quo_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem_q), .a(acc_q[2*WIDTH-1:WIDTH]), .y(rem_fix));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = div_sh >= {1'b0, mag_b_q};
    assign div_diff = div_sh[WIDTH-1:0] - mag_b_q;
    assign div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_b_d    = mag_b_q;
        orig_a_d   = orig_a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_op_d   = div_op_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (func)
                        FUNC_MTHI: hi_d = rs_val;
                        FUNC_MTLO: lo_d = rs_val;
                        FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                            acc_d      = {{WIDTH{1'b0}}, mag_a};
                            mag_b_d    = mag_b;
                            orig_a_d   = rs_val;
                            neg_res_d  = sign_a ^ sign_b;
                            neg_rem_d  = sign_a;
                            div_op_d   = (func == FUNC_DIV) || (func == FUNC_DIVU);
                            div_zero_d = (rt_val == '0);
                            cnt_d      = CNT_W'(WIDTH);
                            state_d    = ((func == FUNC_DIV) || (func == FUNC_DIVU)) ? ST_DIV : ST_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = (state_q == ST_DIV) ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (div_op_q && div_zero_q) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else if (div_op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards the operation, including a correction pending in FIX.
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_b_q    <= '0;
            orig_a_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_op_q   <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_b_q    <= mag_b_d;
            orig_a_q   <= orig_a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_op_q   <= div_op_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign result = (func == FUNC_MFHI) ? hi_q :
                    (func == FUNC_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Directed bench for mdu_seq_unit; {hi,lo} results are scoreboarded on each done pulse.
module tb_mdu_seq_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   func = 6'b0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] result, hi, lo;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    mdu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected {hi,lo}.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no done (hi=0x%0h lo=0x%0h)", hi, lo);
            end else begin
                chk("hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        int n;
        exp_q.push_back({eh, el});
        start = 1'b1; func = f; rs_val = a; rt_val = b;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: busy still high after %0d cycles, expected %0d", nm, n, W + 1);
                break;
            end
        end
        chk({nm, "_busy_cycles"}, 64'(n), 64'(W + 1));
        chk({nm, "_done_after_busy"}, 64'(done), 64'd1);
    endtask

    task automatic mt_op(input logic [5:0] f, input logic [W-1:0] a, input logic fl);
        start = 1'b1; func = f; rs_val = a; flush = fl;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT then MULTU back-to-back: second start lands in the done cycle.
        do_op(FUNC_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg");
        do_op(FUNC_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, "multu");
        func = FUNC_MFHI; #1 chk("mfhi_result", 64'(result), 64'h1);
        func = FUNC_MFLO; #1 chk("mflo_result", 64'(result), 64'hFFFFFFFE);
        func = FUNC_MULT; #1 chk("other_result", 64'(result), 64'h0);

        do_op(FUNC_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        do_op(FUNC_DIVU, 32'h7,        32'h2, 32'h1,        32'h3,        "divu");
        do_op(FUNC_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf");
        do_op(FUNC_DIVU, 32'h5,        32'h0, 32'h5,        32'hFFFFFFFF, "divu_zero");
        do_op(FUNC_DIV,  32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero");

        mt_op(FUNC_MTHI, 32'h12345678, 1'b0);
        chk("mthi", 64'(hi), 64'h12345678);
        chk("mthi_no_busy", {62'd0, busy, done}, 64'd0);
        mt_op(FUNC_MTLO, 32'h9ABCDEF0, 1'b0);
        chk("mtlo", 64'(lo), 64'h9ABCDEF0);

        // MULT 3x4 flushed at cycle 10, with an MTHI start pulsed while busy.
        start = 1'b1; func = FUNC_MULT; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (c == 3) begin
                func = FUNC_MTHI;
                rs_val = 32'hDEADBEEF;
            end
            flush = (c == 10);
            if (c == 5) begin
                chk("busy_mid_op", 64'(busy), 64'd1);
                chk("hi_old_mid_op", 64'(hi), 64'h12345678);
            end
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_done", {62'd0, busy, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
        repeat (40) @(negedge clk);
        chk("flush_hilo_later", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

        // flush and start together in IDLE: start ignored.
        mt_op(FUNC_MTLO, 32'h11111111, 1'b1);
        chk("flush_start_idle_lo", 64'(lo), 64'h9ABCDEF0);

        // Asynchronous reset during a MULT.
        start = 1'b1; func = FUNC_MULT; rs_val = 32'd5; rt_val = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        chk("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(FUNC_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
